alu_sequencer: RTL

Sequences one decoded ALU instruction at a time through the shared ALU and its single register-file write port. It accepts decoder output over a valid/ready handshake, holds the ALU controls stable for a fixed execution latency, and captures both ALU results. It then serializes the up-to-two writebacks (Y1, Y2) onto the one write port and traps invalid encodings. It sits between the ALU instruction decoder and the ALU/register file in the control path.

---
 rtl/alu_sequencer_if.sv | 64 ++++++
 rtl/alu_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle between decoder, sequencer, ALU and register-file write port.
// The slave modport is the sequencer's view; master is the surroundings.
interface alu_sequencer_if;
    logic        dec_valid;
    logic        dec_ready;
    logic        dec_invalid;
    logic [2:0]  dec_op;
    logic        dec_form;
    logic [1:0]  dec_vec;
    logic        dec_const_c;
    logic [31:0] dec_constant;
    logic [3:0]  dec_zero_reg;
    logic [3:0]  dec_a_sel;
    logic [3:0]  dec_b_sel;
    logic [3:0]  dec_c_sel;
    logic [3:0]  dec_d_sel;
    logic [3:0]  dec_y1_sel;
    logic [3:0]  dec_y2_sel;
    logic [1:0]  dec_write;

    logic        alu_start;
    logic [2:0]  alu_op;
    logic        alu_form;
    logic [1:0]  alu_vec;
    logic        alu_const_c;
    logic [31:0] alu_constant;
    logic [3:0]  alu_zero_reg;
    logic [3:0]  alu_a_sel;
    logic [3:0]  alu_b_sel;
    logic [3:0]  alu_c_sel;
    logic [3:0]  alu_d_sel;
    logic [31:0] alu_y1;
    logic [31:0] alu_y2;

    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        exc_invalid;
    logic        busy;

    modport slave (
        input  dec_valid, dec_invalid, dec_op, dec_form,
        input  dec_vec, dec_const_c, dec_constant, dec_zero_reg,
        input  dec_a_sel, dec_b_sel, dec_c_sel, dec_d_sel,
        input  dec_y1_sel, dec_y2_sel, dec_write,
        input  alu_y1, alu_y2,
        output dec_ready, alu_start, alu_op, alu_form,
        output alu_vec, alu_const_c, alu_constant, alu_zero_reg,
        output alu_a_sel, alu_b_sel, alu_c_sel, alu_d_sel,
        output rf_we, rf_waddr, rf_wdata, exc_invalid, busy
    );

    modport master (
        output dec_valid, dec_invalid, dec_op, dec_form,
        output dec_vec, dec_const_c, dec_constant, dec_zero_reg,
        output dec_a_sel, dec_b_sel, dec_c_sel, dec_d_sel,
        output dec_y1_sel, dec_y2_sel, dec_write,
        output alu_y1, alu_y2,
        input  dec_ready, alu_start, alu_op, alu_form,
        input  alu_vec, alu_const_c, alu_constant, alu_zero_reg,
        input  alu_a_sel, alu_b_sel, alu_c_sel, alu_d_sel,
        input  rf_we, rf_waddr, rf_wdata, exc_invalid, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Runs one decoded ALU instruction at a time: hold controls for the ALU
// latency, then serialize up to two writebacks onto one RF write port.
module alu_sequencer #(
    parameter int ALU_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WB1,
        S_WB2,
        S_TRAP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_wr;
    logic [3:0]  r_y1_sel;
    logic [3:0]  r_y2_sel;
    logic [31:0] r_y2;

    logic [2:0]  r_op;
    logic        r_form;
    logic [1:0]  r_vec;
    logic        r_const_c;
    logic [31:0] r_constant;
    logic [3:0]  r_zero_reg;
    logic [3:0]  r_a_sel;
    logic [3:0]  r_b_sel;
    logic [3:0]  r_c_sel;
    logic [3:0]  r_d_sel;

    logic        r_start;
    logic        r_rf_we;
    logic [3:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_exc;
    logic        r_busy;

    logic        w_accept;
    logic        w_invalid;
    logic [1:0]  w_wr;

    assign w_accept  = (r_state == S_IDLE) & bus.dec_valid;
    assign w_invalid = bus.dec_invalid | (bus.dec_form & bus.dec_const_c);
    // Register 0 is hardwired, so a write to it is dropped here.
    assign w_wr[0]   = bus.dec_write[0] & (bus.dec_y1_sel != 4'd0);
    assign w_wr[1]   = bus.dec_write[1] & (bus.dec_y2_sel != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 2'b00;
            r_y1_sel   <= 4'd0;
            r_y2_sel   <= 4'd0;
            r_y2       <= 32'd0;
            r_op       <= 3'd0;
            r_form     <= 1'b0;
            r_vec      <= 2'd0;
            r_const_c  <= 1'b0;
            r_constant <= 32'd0;
            r_zero_reg <= 4'd0;
            r_a_sel    <= 4'd0;
            r_b_sel    <= 4'd0;
            r_c_sel    <= 4'd0;
            r_d_sel    <= 4'd0;
            r_start    <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 4'd0;
            r_rf_wdata <= 32'd0;
            r_exc      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= bus.dec_op;
                        r_form     <= bus.dec_form;
                        r_vec      <= bus.dec_vec;
                        r_const_c  <= bus.dec_const_c;
                        r_constant <= bus.dec_constant;
                        r_zero_reg <= bus.dec_zero_reg;
                        r_a_sel    <= bus.dec_a_sel;
                        r_b_sel    <= bus.dec_b_sel;
                        r_c_sel    <= bus.dec_c_sel;
                        r_d_sel    <= bus.dec_d_sel;
                        r_y1_sel   <= bus.dec_y1_sel;
                        r_y2_sel   <= bus.dec_y2_sel;
                        r_wr       <= w_wr;
                        r_busy     <= 1'b1;
                        if (w_invalid) begin
                            r_state <= S_TRAP;
                            r_exc   <= 1'b1;
                        end else begin
                            r_state <= S_EXEC;
                            r_cnt   <= LAT_M1;
                            r_start <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_start <= 1'b0;
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Y1 goes straight into the write-data register.
                        r_y2 <= bus.alu_y2;
                        if (r_wr[0]) begin
                            r_state    <= S_WB1;
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_y1_sel;
                            r_rf_wdata <= bus.alu_y1;
                        end else if (r_wr[1]) begin
                            r_state    <= S_WB2;
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_y2_sel;
                            r_rf_wdata <= bus.alu_y2;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_WB1: begin
                    if (r_wr[1]) begin
                        r_state    <= S_WB2;
                        r_rf_waddr <= r_y2_sel;
                        r_rf_wdata <= r_y2;
                    end else begin
                        r_state    <= S_IDLE;
                        r_rf_we    <= 1'b0;
                        r_rf_waddr <= 4'd0;
                        r_rf_wdata <= 32'd0;
                        r_busy     <= 1'b0;
                    end
                end
                S_WB2: begin
                    r_state    <= S_IDLE;
                    r_rf_we    <= 1'b0;
                    r_rf_waddr <= 4'd0;
                    r_rf_wdata <= 32'd0;
                    r_busy     <= 1'b0;
                end
                S_TRAP: begin
                    r_state <= S_IDLE;
                    r_exc   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dec_ready    = (r_state == S_IDLE) & ~rst;
    assign bus.alu_start    = r_start;
    assign bus.alu_op       = r_op;
    assign bus.alu_form     = r_form;
    assign bus.alu_vec      = r_vec;
    assign bus.alu_const_c  = r_const_c;
    assign bus.alu_constant = r_constant;
    assign bus.alu_zero_reg = r_zero_reg;
    assign bus.alu_a_sel    = r_a_sel;
    assign bus.alu_b_sel    = r_b_sel;
    assign bus.alu_c_sel    = r_c_sel;
    assign bus.alu_d_sel    = r_d_sel;
    assign bus.rf_we        = r_rf_we;
    assign bus.rf_waddr     = r_rf_waddr;
    assign bus.rf_wdata     = r_rf_wdata;
    assign bus.exc_invalid  = r_exc;
    assign bus.busy         = r_busy;

endmodule
